mem_debug_dumper: RTL and testbench

//  Debug-side reader for the MEM stage data-memory debug port: on command, sweeps
//  i_debug_addr over the first N_WORDS words, captures each 32-bit debug word and

---
 rtl/mem_debug_dumper.sv | 130 +++++++++++++
 tb/tb_mem_debug_dumper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_debug_dumper.sv
// Debug-side memory dumper: sweeps the MEM debug address over the first N_WORDS words
// and streams each captured word to the UART TX byte interface, least significant byte first.
module mem_debug_dumper #(
    parameter int unsigned INST_SZ = 32,
    parameter int unsigned MEM_SZ  = 10,
    parameter int unsigned N_WORDS = 2 ** (MEM_SZ - 2)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [INST_SZ-1:0] i_debug_mem,
    input  logic               i_tx_done,
    output logic [INST_SZ-1:0] o_debug_addr,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned WCNT_W = $clog2(N_WORDS) + 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [WCNT_W-1:0]   word_cnt, word_cnt_nxt;
    logic [1:0]          byte_cnt, byte_cnt_nxt;
    logic [INST_SZ-1:0]  word_reg, word_reg_nxt;
    logic [INST_SZ-1:0]  addr_nxt;
    logic [7:0]          tx_data_nxt;
    logic                tx_start_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // State, counters, capture register and all outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            word_reg     <= '0;
            o_debug_addr <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state        <= state_nxt;
            word_cnt     <= word_cnt_nxt;
            byte_cnt     <= byte_cnt_nxt;
            word_reg     <= word_reg_nxt;
            o_debug_addr <= addr_nxt;
            o_tx_data    <= tx_data_nxt;
            o_tx_start   <= tx_start_nxt;
            o_busy       <= busy_nxt;
            o_done       <= done_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        byte_cnt_nxt = byte_cnt;
        word_reg_nxt = word_reg;
        addr_nxt     = o_debug_addr;
        tx_data_nxt  = o_tx_data;
        tx_start_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    word_cnt_nxt = '0;
                    state_nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_nxt  = INST_SZ'({word_cnt, 2'b00});
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                word_reg_nxt = i_debug_mem;
                byte_cnt_nxt = 2'd0;
                state_nxt    = S_SEND;
            end
            S_SEND: begin
                tx_data_nxt  = word_reg[{byte_cnt, 3'b000} +: 8];
                tx_start_nxt = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                // A done pulse coinciding with our own start pulse belongs to an earlier byte
                if (i_tx_done && !o_tx_start) begin
                    if (byte_cnt == 2'd3) begin
                        state_nxt = S_NEXT;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 2'd1;
                        state_nxt    = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (word_cnt == LAST_WORD) begin
                    state_nxt = S_DONE;
                end else begin
                    word_cnt_nxt = word_cnt + WCNT_W'(1);
                    state_nxt    = S_ADDR;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Directed bench for mem_debug_dumper with a 4-word memory model and a UART TX model.
module tb_mem_debug_dumper;

    localparam int unsigned NW = 4;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_tx_done;
    logic [31:0] i_debug_mem;
    logic [31:0] o_debug_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    logic        uart_done = 1'b0;
    logic        inj_done  = 1'b0;
    logic [31:0] mem [NW];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]  bytes_q [$];
    logic [31:0] addr_q  [$];
    int          done_cnt = 0;

    int          uart_delay  = 3;
    bit          dbl_done    = 1'b0;
    int          unstable    = 0;
    int          extra_start = 0;
    logic [7:0]  held;

    assign i_tx_done   = uart_done | inj_done;
    assign i_debug_mem = mem[o_debug_addr[3:2]];

    mem_debug_dumper #(
        .INST_SZ (32),
        .MEM_SZ  (10),
        .N_WORDS (NW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_debug_mem  (i_debug_mem),
        .i_tx_done    (i_tx_done),
        .o_debug_addr (o_debug_addr),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte/address/done monitor
    initial forever begin
        @(posedge i_clk);
        #1;
        if (o_tx_start) begin
            if (bytes_q.size() % 4 == 0) addr_q.push_back(o_debug_addr);
            bytes_q.push_back(o_tx_data);
        end
        if (o_done) done_cnt++;
    end

    // UART TX model: answers each start with a done pulse after uart_delay cycles
    initial forever begin
        @(posedge i_clk);
        #1;
        while (o_tx_start) begin
            held = o_tx_data;
            repeat (uart_delay - 1) begin
                @(posedge i_clk);
                #1;
                if (o_tx_data !== held) unstable++;
                if (o_tx_start) extra_start++;
            end
            uart_done = 1'b1;
            @(posedge i_clk);
            #1;
            if (dbl_done) begin
                @(posedge i_clk);
                #1;
            end
            uart_done = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check($sformatf("%s_addr", tag),  o_debug_addr, 32'h0);
        check($sformatf("%s_data", tag),  32'(o_tx_data), 32'h0);
        check($sformatf("%s_start", tag), 32'(o_tx_start), 32'h0);
        check($sformatf("%s_busy", tag),  32'(o_busy), 32'h0);
        check($sformatf("%s_done", tag),  32'(o_done), 32'h0);
    endtask

    // One complete dump; noise injects stray done pulses and a stray start mid-run
    task automatic do_dump(input bit noise, input int budget, input string tag);
        int          t0;
        int          nstart     = 0;
        int          busy_drop  = 0;
        bit          got_done   = 1'b0;
        bit          seen_start = 1'b0;
        bit          extra      = 1'b0;
        logic [31:0] w;
        logic [31:0] got;
        logic [31:0] exp;

        bytes_q.delete();
        addr_q.delete();
        done_cnt = 0;
        @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        t0 = cyc;
        for (int n = 0; n < budget && !got_done; n++) begin
            @(posedge i_clk);
            #1;
            inj_done = 1'b0;
            i_start  = 1'b0;
            if (o_done) begin
                got_done = 1'b1;
            end else begin
                if (!o_busy) busy_drop++;
                if (o_tx_start) begin
                    nstart++;
                    if (!seen_start) begin
                        seen_start = 1'b1;
                        check($sformatf("%s_latency", tag), 32'(cyc - t0), 32'd3);
                    end
                end
                if (noise) begin
                    if (o_tx_start) begin
                        inj_done = 1'b1;
                    end else if (nstart == 6 && !extra) begin
                        i_start = 1'b1;
                        extra   = 1'b1;
                    end
                end
            end
        end
        inj_done = 1'b0;
        i_start  = 1'b0;
        check($sformatf("%s_done_seen", tag), 32'(got_done), 32'd1);
        check($sformatf("%s_busy_held", tag), 32'(busy_drop), 32'd0);
        repeat (10) @(posedge i_clk);
        #1;
        check($sformatf("%s_done_cnt", tag),  32'(done_cnt), 32'd1);
        check($sformatf("%s_busy_end", tag),  32'(o_busy), 32'd0);
        check($sformatf("%s_addr_hold", tag), o_debug_addr, 32'd12);
        check($sformatf("%s_nbytes", tag),    32'(bytes_q.size()), 32'd16);
        for (int i = 0; i < NW; i++) begin
            got = (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF;
            check($sformatf("%s_addr%0d", tag, i), got, 32'(4 * i));
        end
        for (int j = 0; j < 4 * NW; j++) begin
            w   = mem[j / 4];
            exp = (w >> (8 * (j % 4))) & 32'hFF;
            got = (j < bytes_q.size()) ? 32'(bytes_q[j]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, j), got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < NW; k++) mem[k] = 32'(k);

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_idle_outputs("reset");
        #3 i_rst_n = 1'b1;

        // Plain dump of words 0..3
        do_dump(1'b0, 500, "basic");

        // Byte ordering with a distinctive first word
        mem[0] = 32'hA1B2_C3D4;
        do_dump(1'b0, 500, "pattern");
        mem[0] = 32'h0;

        // Stray done in IDLE, stray done with o_tx_start and in SEND, stray start in WAIT
        @(posedge i_clk);
        #1 inj_done = 1'b1;
        @(posedge i_clk);
        #1 inj_done = 1'b0;
        check("idle_done_busy", 32'(o_busy), 32'd0);
        dbl_done = 1'b1;
        do_dump(1'b1, 500, "noise");
        dbl_done = 1'b0;

        // Reset after the fifth byte, then a fresh full dump
        bytes_q.delete();
        addr_q.delete();
        done_cnt = 0;
        @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        for (int n = 0; n < 500 && bytes_q.size() < 5; n++) begin
            @(posedge i_clk);
            #2;
        end
        check("abort_reach5", 32'(bytes_q.size()), 32'd5);
        #1 i_rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_nbytes", 32'(bytes_q.size()), 32'd5);
        do_dump(1'b0, 500, "restart");

        // UART stalls 50 cycles per byte
        uart_delay  = 50;
        unstable    = 0;
        extra_start = 0;
        do_dump(1'b0, 3000, "stall");
        check("stall_data_stable", 32'(unstable), 32'd0);
        check("stall_extra_start", 32'(extra_start), 32'd0);
        uart_delay = 3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
